hex_scan_driver: RTL and testbench

HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

---
 rtl/hex_scan_pkg.sv | 33 +++
 rtl/hex7seg.sv | 18 +
 rtl/hex_scan_driver.sv | 118 +++++++++++
 tb/tb_hex_scan_driver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_scan_pkg.sv
// ============================================================
// hex_scan_pkg : segment table, bit positions, polarity helper
// Rev 1.0
// ============================================================
`default_nettype none

package hex_scan_pkg;

    localparam int SEG_W = 7;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high glyphs, bit SEG_A..SEG_G
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_W-1:0] seg_polarity(
        input logic [SEG_W-1:0] seg_act,
        input bit               active_low
    );
        return active_low ? ~seg_act : seg_act;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex7seg.sv
// ============================================================
// hex7seg : combinational nibble to active-high 7-segment glyph
// Rev 1.0
// ============================================================
`default_nettype none

module hex7seg
    import hex_scan_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

`default_nettype wire

// File: rtl/hex_scan_driver.sv
// ============================================================
// hex_scan_driver : multiplexed hex display scanner with
//                   frame-synchronous double-buffered update
// Rev 1.0
// ============================================================
`default_nettype none

module hex_scan_driver
    import hex_scan_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_suppress,
    output logic                  ready,
    output logic [SEG_W-1:0]      seg,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_tick
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PS_W  = $clog2(PRESCALE);

    logic [PS_W-1:0]       presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_val_q, act_val_q;
    logic [DIGITS-1:0]     shadow_blank_q, act_blank_q;
    logic                  pending_q;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [DIGITS-1:0]     dig_en_q, dig_en_d;
    logic                  frame_tick_q;

    logic                  slot_end, frame_bnd, accept, dark;
    logic [3:0]            nibble;
    logic [SEG_W-1:0]      glyph;
    logic [DIGITS-1:0]     lz_dark, dig_act;
    logic                  zero_run;

    assign slot_end  = (presc_q == PS_W'(PRESCALE - 1));
    assign frame_bnd = slot_end && (idx_q == IDX_W'(DIGITS - 1));
    // Only one of capture/transfer can act: capture needs pending=0, transfer pending=1
    assign accept    = load && !pending_q;

    assign presc_d = slot_end ? '0 : presc_q + PS_W'(1);
    assign idx_d   = frame_bnd ? '0 : (slot_end ? idx_q + IDX_W'(1) : idx_q);
    assign nibble  = act_val_q[{idx_q, 2'b00} +: 4];

    hex7seg u_dec (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    // A digit is a leading zero when it and every more-significant digit are zero
    always_comb begin
        zero_run = 1'b1;
        lz_dark  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (act_val_q[4*i +: 4] == 4'h0);
            lz_dark[i] = zero_run && (i != 0);
        end
    end

    assign dark  = act_blank_q[idx_q] || (lz_suppress && lz_dark[idx_q]);
    assign seg_d = seg_polarity(dark ? '0 : glyph, SEG_ACTIVE_LOW);

    always_comb begin
        dig_act = '0;
        if (presc_q != '0) begin
            dig_act[idx_q] = 1'b1;
        end
        dig_en_d = dig_act ^ {DIGITS{DIG_ACTIVE_LOW}};
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            presc_q        <= '0;
            idx_q          <= '0;
            shadow_val_q   <= '0;
            shadow_blank_q <= '0;
            pending_q      <= 1'b0;
            act_val_q      <= '0;
            act_blank_q    <= '1;
            seg_q          <= seg_polarity('0, SEG_ACTIVE_LOW);
            dig_en_q       <= {DIGITS{DIG_ACTIVE_LOW}};
            frame_tick_q   <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
            frame_tick_q <= frame_bnd;
            if (accept) begin
                shadow_val_q   <= value;
                shadow_blank_q <= blank_mask;
                pending_q      <= 1'b1;
            end else if (frame_bnd && pending_q) begin
                act_val_q   <= shadow_val_q;
                act_blank_q <= shadow_blank_q;
                pending_q   <= 1'b0;
            end
        end
    end

    assign ready      = !pending_q;
    assign seg        = seg_q;
    assign dig_en     = dig_en_q;
    assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_scan_driver.sv
// ============================================================
// tb_hex_scan_driver : scoreboard bench, DIGITS=4 PRESCALE=4
// Rev 1.0
// ============================================================
`default_nettype none

module tb_hex_scan_driver;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic        lz_suppress = 1'b0;
    logic        ready;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
    } exp_t;

    exp_t exp_q[$];
    int   guard_run = 0;

    // Inverted (active-low) glyphs for 0..F
    logic [6:0] inv_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    hex_scan_driver #(
        .DIGITS         (4),
        .PRESCALE       (4),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .load        (load),
        .value       (value),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .ready       (ready),
        .seg         (seg),
        .dig_en      (dig_en),
        .frame_tick  (frame_tick)
    );

    always #5 clock = ~clock;

    // Monitor: compares the first lit cycle of each slot against the queue
    always @(negedge clock) begin
        exp_t e;
        if (!resetn) begin
            guard_run = 0;
        end else if (dig_en == 4'hF) begin
            guard_run++;
        end else begin
            if (guard_run != 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (seg !== e.seg || dig_en !== e.dig) begin
                    errors++;
                    $display("FAIL slot: seg=%h dig_en=%b, required seg=%h dig_en=%b",
                             seg, dig_en, e.seg, e.dig);
                end
                checks++;
                if (guard_run != 1) begin
                    errors++;
                    $display("FAIL guard: guard cycles=%0d, required 1", guard_run);
                end
            end
            guard_run = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_reset_state();
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dig", 32'(dig_en), 32'hF);
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_tick", 32'(frame_tick), 32'h0);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] b);
        @(negedge clock);
        value      = v;
        blank_mask = b;
        load       = 1'b1;
        @(posedge clock);
        #1 load = 1'b0;
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (frame_tick) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL tick_timeout: frame_tick=0, required 1 within 200 cycles");
        end else begin
            @(negedge clock);
            check("tick_width", 32'(frame_tick), 32'h0);
        end
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        exp_q.push_back('{seg: s0, dig: 4'b1110});
        exp_q.push_back('{seg: s1, dig: 4'b1101});
        exp_q.push_back('{seg: s2, dig: 4'b1011});
        exp_q.push_back('{seg: s3, dig: 4'b0111});
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_state();
        resetn = 1'b1;

        // Out of reset every digit is blanked
        wait_tick();
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        drain();

        do_load(16'h12AF, 4'h0);
        @(negedge clock);
        check("ready_after_load", 32'(ready), 32'h0);
        wait_tick();
        check("ready_after_xfer", 32'(ready), 32'h1);
        push_frame(7'h0E, 7'h08, 7'h24, 7'h79);
        drain();

        lz_suppress = 1'b1;
        do_load(16'h0050, 4'h0);
        wait_tick();
        push_frame(7'h40, 7'h12, 7'h7F, 7'h7F);
        drain();
        lz_suppress = 1'b0;

        do_load(16'h1111, 4'h0);
        @(negedge clock);
        check("ready_busy", 32'(ready), 32'h0);
        do_load(16'hBEEF, 4'h0);
        wait_tick();
        push_frame(7'h79, 7'h79, 7'h79, 7'h79);
        drain();
        wait_tick();
        push_frame(7'h79, 7'h79, 7'h79, 7'h79);
        drain();

        for (int v = 0; v < 16; v++) begin
            do_load(16'(v), 4'b1110);
            wait_tick();
            push_frame(inv_tab[v], 7'h7F, 7'h7F, 7'h7F);
            drain();
        end

        // Reset while an update is pending: it must be discarded
        do_load(16'h2222, 4'h0);
        repeat (2) @(negedge clock);
        check("ready_pending", 32'(ready), 32'h0);
        resetn = 1'b0;
        @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        check_reset_state();
        wait_tick();
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
